sum_window_avg: RTL

- Downstream consumer of the four-lane adder's registered 17-bit sum.
- Accumulates a fixed window of 2^LOG2_N consecutive sums, then presents the window total and the truncated mean on a valid/ready output.
- Provides the decimated average stage feeding result capture and readout logic.

---
 rtl/sum_window_avg_pkg.sv | 12 +
 rtl/sum_window_avg_if.sv | 30 +++
 rtl/sum_window_avg.sv | 82 ++++++++
 3 files changed

// File: rtl/sum_window_avg_pkg.sv
// Shared definitions for the adder output stage and the windowed averager.
// The state encoding and the adder sum width live here so both blocks agree.
package sum_window_avg_pkg;

  localparam int ADDER_SUM_W = 17;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/sum_window_avg_if.sv
// Valid/ready bundle between the adder, the window averager, and the result consumer.
// The slave modport is the averager's view; the master modport is the surrounding logic's view.
interface sum_window_avg_if
  import sum_window_avg_pkg::*;
#(
  parameter int DW     = ADDER_SUM_W,
  parameter int LOG2_N = 3
);

  localparam int SW = DW + LOG2_N;

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [DW-1:0] out_avg;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_avg
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_avg
  );

endinterface

// File: rtl/sum_window_avg.sv
// Sums windows of 2^LOG2_N adder results and presents the total and floor mean.
// A completed result is held until the consumer takes it; input stalls meanwhile.
module sum_window_avg
  import sum_window_avg_pkg::*;
#(
  parameter int DW     = ADDER_SUM_W,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  sum_window_avg_if.slave   bus,
  input  logic              flush,
  output logic [LOG2_N-1:0] count,
  output logic              overrun
);

  localparam int SW = DW + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST = {LOG2_N{1'b1}};

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] acc;
  logic [SW-1:0] sum_next;
  logic          accept;
  logic          window_done;
  logic          take;

  assign bus.in_ready = (state == ST_ACCUM);
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign window_done  = accept && (count == LAST);
  assign take         = bus.out_valid && bus.out_ready;
  assign sum_next     = acc + SW'(bus.in_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACCUM: if (window_done) state_next = ST_HOLD;
      ST_HOLD:  if (take)        state_next = ST_ACCUM;
      default:                   state_next = ST_ACCUM;
    endcase
  end

  // Flush only acts while accumulating; a held result survives it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      count         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_avg   <= '0;
      overrun       <= 1'b0;
    end else begin
      overrun <= bus.in_valid && !bus.in_ready;
      if (state == ST_ACCUM) begin
        if (flush) begin
          acc   <= '0;
          count <= '0;
        end else if (window_done) begin
          bus.out_sum   <= sum_next;
          bus.out_avg   <= sum_next[SW-1:LOG2_N];
          bus.out_valid <= 1'b1;
          acc           <= '0;
          count         <= '0;
        end else if (accept) begin
          acc   <= sum_next;
          count <= count + 1'b1;
        end
      end else if (take) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
